// File: rtl/mult_control_if.sv
// Strobe/handshake bundle between the multiplier control FSM and the CPU/ACC datapath.
// Latency: none (wires only).
// Backpressure: none; St is a level request held until Done is observed.
interface mult_control_if #(
    parameter int CW = 6
);
    logic          St;
    logic          M;
    logic          Load;
    logic          Ad;
    logic          Sh;
    logic          Done;
    logic          Busy;
    logic [CW-1:0] Count;

    // Controller side: takes the request and multiplier LSB, drives the ACC strobes.
    modport master (
        input  St,
        input  M,
        output Load,
        output Ad,
        output Sh,
        output Done,
        output Busy,
        output Count
    );

    // Datapath side: raises the request, supplies the LSB, and follows the strobes.
    modport slave (
        output St,
        output M,
        input  Load,
        input  Ad,
        input  Sh,
        input  Done,
        input  Busy,
        input  Count
    );
endinterface

// File: rtl/mult_control.sv
// Shift-add multiplier control: sequences Load, then Ad/Sh per multiplier bit, then Done.
// Latency: N+1+popcount(multiplier) edges from the St-sampling edge to the first Done cycle.
// Backpressure: Done is held until St drops; St changes while Busy are ignored.
module mult_control #(
    parameter int N  = 32,
    parameter int CW = 6      // 2**CW must exceed N so Count can reach N without wrapping
) (
    input  logic            Clk,
    input  logic            reset,
    mult_control_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    logic load_c;
    logic ad_c;
    logic sh_c;
    logic done_c;
    logic busy_c;

    // State and shift counter; reset drops straight back to IDLE with a cleared count.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode from the current state, M and St.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_c  = 1'b0;
        ad_c    = 1'b0;
        sh_c    = 1'b0;
        done_c  = 1'b0;
        busy_c  = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = bus.St;
                if (bus.St) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                busy_c = 1'b1;
                if (bus.M) begin
                    // Add this cycle, the matching shift follows in SHIFT.
                    ad_c    = 1'b1;
                    state_d = SHIFT;
                end else begin
                    // Zero bit: skip the add and shift immediately.
                    sh_c    = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == LAST_STEP) ? DONE : CHECK;
                end
            end
            SHIFT: begin
                busy_c  = 1'b1;
                sh_c    = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST_STEP) ? DONE : CHECK;
            end
            DONE: begin
                done_c = 1'b1;
                if (!bus.St) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are forced low while reset is asserted, even though Load follows St in IDLE.
    assign bus.Load  = load_c & reset;
    assign bus.Ad    = ad_c   & reset;
    assign bus.Sh    = sh_c   & reset;
    assign bus.Done  = done_c & reset;
    assign bus.Busy  = busy_c & reset;
    assign bus.Count = cnt_q;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: drives it from a 65-bit ACC model and checks products against plain multiplication.
// Latency: checks the Done arrival edge against N+1+popcount(multiplier).
// Backpressure: exercises St held in DONE, St toggled while Busy, and asynchronous reset mid-operation.
module tb_mult_control;

    localparam int N  = 32;
    localparam int CW = 6;

    logic Clk;
    logic reset;

    mult_control_if #(.CW(CW)) bus ();

    mult_control #(.N(N), .CW(CW)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] mplier = '0;
    logic [31:0] mcand  = '0;
    logic [64:0] acc    = '0;

    // Datapath-side monitor state
    int          sh_seen  = 0;
    logic [31:0] ad_mask  = '0;
    logic        ad_pend  = 1'b0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign bus.M = acc[0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Accumulator model: the datapath the FSM is meant to steer.
    always @(posedge Clk) begin
        if (bus.Load)
            acc <= {33'd0, mplier};
        else if (bus.Ad)
            acc <= {({1'b0, acc[63:32]} + {1'b0, mcand}), acc[31:0]};
        else if (bus.Sh)
            acc <= acc >> 1;
    end

    // Strobe protocol monitor, sampled on the falling edge.
    always @(negedge Clk) begin
        chk("strobe_exclusive", 64'(int'(bus.Load) + int'(bus.Ad) + int'(bus.Sh) <= 1), 64'd1);
        if (bus.Load) begin
            sh_seen  = 0;
            ad_mask  = '0;
            ad_pend  = 1'b0;
        end
        if (bus.Ad) begin
            chk("ad_without_sh", 64'(ad_pend), 64'd0);
            if (sh_seen < 32) ad_mask[sh_seen] = 1'b1;
            ad_pend = 1'b1;
        end
        if (bus.Sh) begin
            ad_pend = 1'b0;
            sh_seen++;
        end
    end

    // One multiply from IDLE; leaves the FSM in DONE (or IDLE if St was low on arrival).
    task automatic run_op(input logic [31:0] mp, input logic [31:0] mc, input bit rnd_st);
        int   edges;
        bit   seen;
        logic [63:0] prod;
        mplier = mp;
        mcand  = mc;
        bus.St = 1'b1;
        #1;
        chk("load_on_start", 64'(bus.Load), 64'd1);
        edges = 0;
        seen  = 0;
        while (edges < 200 && !seen) begin
            @(posedge Clk);
            edges++;
            #1;
            if (bus.Done) seen = 1;
            else if (rnd_st && bus.Busy) bus.St = 1'($urandom_range(0, 1));
        end
        chk("done_reached", 64'(seen), 64'd1);
        chk("done_latency", 64'(edges), 64'(N + 1 + $countones(mp)));
        chk("count_at_done", 64'(bus.Count), 64'(N));
        prod = 64'(mp) * 64'(mc);
        chk("product", acc[63:0], prod);
        chk("ad_steps", 64'(ad_mask), 64'(mp));
        chk("sh_pulses", 64'(sh_seen), 64'(N));
    endtask

    task automatic finish_op();
        bus.St = 1'b0;
        @(posedge Clk);
        #1;
        chk("idle_done_low", 64'(bus.Done), 64'd0);
        chk("idle_busy_low", 64'(bus.Busy), 64'd0);
    endtask

    initial begin
        int guard;
        reset  = 1'b0;
        bus.St = 1'b1;
        #2;
        // Reset state: everything quiet even with St high.
        chk("rst_load", 64'(bus.Load), 64'd0);
        chk("rst_ad",   64'(bus.Ad),   64'd0);
        chk("rst_sh",   64'(bus.Sh),   64'd0);
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_busy", 64'(bus.Busy), 64'd0);
        chk("rst_count", 64'(bus.Count), 64'd0);
        bus.St = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        reset = 1'b1;
        @(posedge Clk);
        #1;

        // Multiplier zero: Load then 32 plain shifts.
        run_op(32'h0000_0000, 32'h1234_5678, 0);
        finish_op();

        // All-ones multiplier: alternating Ad/Sh, longest latency.
        run_op(32'hFFFF_FFFF, 32'hDEAD_BEEF, 0);
        finish_op();

        // Multiplier 11: adds at steps 0, 1, 3; then hold St in DONE.
        run_op(32'h0000_000B, 32'h0000_0007, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1;
            chk("hold_done", 64'(bus.Done), 64'd1);
            chk("hold_no_load", 64'(bus.Load), 64'd0);
        end
        finish_op();
        // New request straight after the single IDLE cycle.
        run_op(32'h8000_0001, 32'hFFFF_FFFF, 0);
        finish_op();

        // Asynchronous reset in the middle of an operation.
        mplier = $urandom;
        mcand  = $urandom;
        bus.St = 1'b1;
        guard  = 0;
        do begin
            @(posedge Clk);
            #1;
            guard++;
        end while (bus.Count != 6'd17 && guard < 100);
        chk("reach_count17", 64'(bus.Count), 64'd17);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_load", 64'(bus.Load), 64'd0);
        chk("arst_ad",   64'(bus.Ad),   64'd0);
        chk("arst_sh",   64'(bus.Sh),   64'd0);
        chk("arst_busy", 64'(bus.Busy), 64'd0);
        chk("arst_done", 64'(bus.Done), 64'd0);
        chk("arst_count", 64'(bus.Count), 64'd0);
        repeat (2) @(posedge Clk);
        #1;
        chk("arst_count_held", 64'(bus.Count), 64'd0);
        reset = 1'b1;
        run_op(32'h0F0F_1234, 32'h0000_FFFF, 0);
        finish_op();

        // Random multiplies with St toggled while Busy.
        for (int k = 0; k < 200; k++) begin
            run_op($urandom, $urandom, 1);
            finish_op();
            if ($urandom_range(0, 1) == 1) begin
                @(posedge Clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
